// File: rtl/recirc_lanes_if.sv
// Lane bus between the serial-to-parallel front end, the recirculator, the L1 mux and the tester.
// master drives the lane inputs and active; slave is the recirculator view.
interface recirc_lanes_if #(
  parameter int LANES     = 4,
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic [LANES*WIDTH-1:0]     data_in;
  logic [LANES-1:0]           valid_in;
  logic                       active;
  logic [LANES*WIDTH-1:0]     data_act_out;
  logic [LANES-1:0]           valid_act_out;
  logic [LANES*WIDTH-1:0]     data_recirc_out;
  logic [LANES-1:0]           valid_recirc_out;
  logic                       locked;
  logic [LANES*CNT_WIDTH-1:0] recirc_count;

  modport master (
    output data_in, valid_in, active,
    input  data_act_out, valid_act_out, data_recirc_out, valid_recirc_out, locked, recirc_count
  );

  modport slave (
    input  data_in, valid_in, active,
    output data_act_out, valid_act_out, data_recirc_out, valid_recirc_out, locked, recirc_count
  );
endinterface

// File: rtl/recirc_lanes.sv
// Per-lane recirculator: routes valid words to the active path once `active` has qualified a lock.
// Define RECIRC_COUNT_EN to build the per-lane saturating recirculation counters.
module recirc_lanes #(
  parameter int LANES       = 4,
  parameter int WIDTH       = 8,
  parameter int LOCK_CYCLES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input logic           clk,
  input logic           reset,
  recirc_lanes_if.slave bus
);

  localparam int QW = $clog2(LOCK_CYCLES) + 1;

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic            locked;

  logic [LANES*WIDTH-1:0] data_act_p1;
  logic [LANES*WIDTH-1:0] data_recirc_p1;
  logic [LANES-1:0]       vld_act_p1;
  logic [LANES-1:0]       vld_recirc_p1;

  assign locked = (state_q == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UNLOCKED;
      qcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
    end
  end

  // Any low on active drops lock or restarts qualification immediately.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    case (state_q)
      UNLOCKED: begin
        if (!bus.active) begin
          qcnt_d = '0;
        end else if (qcnt_q == QW'(LOCK_CYCLES - 1)) begin
          state_d = LOCKED;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      LOCKED: begin
        if (!bus.active) begin
          state_d = UNLOCKED;
          qcnt_d  = '0;
        end
      end
      default: begin
        state_d = UNLOCKED;
        qcnt_d  = '0;
      end
    endcase
  end

  // Stage p0 -> p1: route each lane on the pre-edge lock state; unrouted paths carry zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_act_p1    <= '0;
      data_recirc_p1 <= '0;
      vld_act_p1     <= '0;
      vld_recirc_p1  <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        vld_act_p1[i]    <= bus.valid_in[i] & locked;
        vld_recirc_p1[i] <= bus.valid_in[i] & ~locked;
        data_act_p1[i*WIDTH +: WIDTH]    <= (bus.valid_in[i] && locked)  ? bus.data_in[i*WIDTH +: WIDTH] : '0;
        data_recirc_p1[i*WIDTH +: WIDTH] <= (bus.valid_in[i] && !locked) ? bus.data_in[i*WIDTH +: WIDTH] : '0;
      end
    end
  end

  assign bus.data_act_out     = data_act_p1;
  assign bus.data_recirc_out  = data_recirc_p1;
  assign bus.valid_act_out    = vld_act_p1;
  assign bus.valid_recirc_out = vld_recirc_p1;
  assign bus.locked           = locked;

`ifdef RECIRC_COUNT_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  logic [LANES*CNT_WIDTH-1:0] cnt_p1;

  // Counts advance on the same edge that loads valid_recirc_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p1 <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.valid_in[i] && !locked)
          cnt_p1[i*CNT_WIDTH +: CNT_WIDTH] <= sat_inc(cnt_p1[i*CNT_WIDTH +: CNT_WIDTH]);
      end
    end
  end

  assign bus.recirc_count = cnt_p1;
`else
  assign bus.recirc_count = {(LANES*CNT_WIDTH){1'b0}};
`endif

endmodule

// File: tb/tb_recirc_lanes.sv
// Directed table-driven bench for recirc_lanes (LANES=4, WIDTH=8, LOCK_CYCLES=4, CNT_WIDTH=3).
module tb_recirc_lanes;

  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam int CW    = 3;
  localparam int CMAX  = 7;

  logic clk;
  logic reset;

  recirc_lanes_if #(.LANES(LANES), .WIDTH(WIDTH), .CNT_WIDTH(CW)) bus ();

  recirc_lanes #(.LANES(LANES), .WIDTH(WIDTH), .LOCK_CYCLES(4), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        act;
    logic [3:0]  vin;
    logic [31:0] din;
    logic        lk;
    logic [3:0]  vact;
    logic [3:0]  vrec;
    logic [31:0] dact;
    logic [31:0] drec;
  } vec_t;

  vec_t tbl[$];
  int   nchk;
  int   nerr;
  int   cnt_exp[LANES];

  function automatic vec_t mk(logic rst, logic act, logic [3:0] vin, logic [31:0] din, logic lk,
                              logic [3:0] vact, logic [3:0] vrec, logic [31:0] dact, logic [31:0] drec);
    vec_t v;
    v.rst = rst; v.act = act; v.vin = vin; v.din = din; v.lk = lk;
    v.vact = vact; v.vrec = vrec; v.dact = dact; v.drec = drec;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, want);
    end
  endtask

  function automatic logic [LANES*CW-1:0] pack_cnt();
    logic [LANES*CW-1:0] p;
    p = '0;
`ifdef RECIRC_COUNT_EN
    for (int i = 0; i < LANES; i++) p[i*CW +: CW] = CW'(cnt_exp[i]);
`endif
    return p;
  endfunction

  task automatic drive(input logic rst, input logic act, input logic [3:0] vin, input logic [31:0] din);
    reset        = rst;
    bus.active   = act;
    bus.valid_in = vin;
    bus.data_in  = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    for (int i = 0; i < LANES; i++) cnt_exp[i] = 0;
    reset = 1'b1; bus.active = 1'b0; bus.valid_in = '0; bus.data_in = '0;

    // reset held with traffic and active
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 1, 4'hF, 32'hA3A2A1A0, 0, 4'h0, 4'h0, 32'h0, 32'h0));
    // lock qualification: edges 0-3 recirculate, lock after edge 3
    tbl.push_back(mk(0, 1, 4'hF, 32'hA3A2A1A0, 0, 4'h0, 4'hF, 32'h0, 32'hA3A2A1A0));
    tbl.push_back(mk(0, 1, 4'hF, 32'hA3A2A1A0, 0, 4'h0, 4'hF, 32'h0, 32'hA3A2A1A0));
    tbl.push_back(mk(0, 1, 4'hF, 32'hA3A2A1A0, 0, 4'h0, 4'hF, 32'h0, 32'hA3A2A1A0));
    tbl.push_back(mk(0, 1, 4'hF, 32'hA3A2A1A0, 1, 4'h0, 4'hF, 32'h0, 32'hA3A2A1A0));
    tbl.push_back(mk(0, 1, 4'hF, 32'hB3B2B1B0, 1, 4'hF, 4'h0, 32'hB3B2B1B0, 32'h0));
    // sparse lanes, then idle lanes
    tbl.push_back(mk(0, 1, 4'b0101, 32'h44332211, 1, 4'b0101, 4'h0, 32'h00330011, 32'h0));
    tbl.push_back(mk(0, 1, 4'h0, 32'hFFFFFFFF, 1, 4'h0, 4'h0, 32'h0, 32'h0));
    // unlock: word at the dropping edge still goes active, next word recirculates
    tbl.push_back(mk(0, 0, 4'b0100, 32'h005C0000, 0, 4'b0100, 4'h0, 32'h005C0000, 32'h0));
    tbl.push_back(mk(0, 0, 4'b0100, 32'h006D0000, 0, 4'h0, 4'b0100, 32'h0, 32'h006D0000));
    // glitch pattern 1,1,1,0,1,1,1,1
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, (k != 3), 4'hF, 32'hC3C2C1C0, (k == 7), 4'h0, 4'hF, 32'h0, 32'hC3C2C1C0));
    tbl.push_back(mk(0, 1, 4'hF, 32'hC3C2C1C0, 1, 4'hF, 4'h0, 32'hC3C2C1C0, 32'h0));
    // reset while locked, then reset mid-qualification
    tbl.push_back(mk(1, 1, 4'hF, 32'hD3D2D1D0, 0, 4'h0, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mk(0, 1, 4'h1, 32'h000000E1, 0, 4'h0, 4'h1, 32'h0, 32'h000000E1));
    tbl.push_back(mk(0, 1, 4'h1, 32'h000000E1, 0, 4'h0, 4'h1, 32'h0, 32'h000000E1));
    tbl.push_back(mk(1, 1, 4'h1, 32'h000000E1, 0, 4'h0, 4'h0, 32'h0, 32'h0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 1, 4'h1, 32'h000000E2, (k == 3), 4'h0, 4'h1, 32'h0, 32'h000000E2));
    tbl.push_back(mk(0, 1, 4'h1, 32'h000000E3, 1, 4'h1, 4'h0, 32'h000000E3, 32'h0));

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].rst, tbl[r].act, tbl[r].vin, tbl[r].din);
      for (int i = 0; i < LANES; i++) begin
        if (tbl[r].rst) cnt_exp[i] = 0;
        else if (tbl[r].vrec[i] && cnt_exp[i] < CMAX) cnt_exp[i]++;
      end
      chk("locked",           r, 32'(bus.locked),           32'(tbl[r].lk));
      chk("valid_act_out",    r, 32'(bus.valid_act_out),    32'(tbl[r].vact));
      chk("valid_recirc_out", r, 32'(bus.valid_recirc_out), 32'(tbl[r].vrec));
      chk("data_act_out",     r, bus.data_act_out,          tbl[r].dact);
      chk("data_recirc_out",  r, bus.data_recirc_out,       tbl[r].drec);
      chk("recirc_count",     r, 32'(bus.recirc_count),     32'(pack_cnt()));
    end

    // counter saturation: unlocked, lane 0 valid for 10 cycles
    drive(1, 0, 4'h0, 32'h0);
    chk("sat_reset", 100, 32'(bus.recirc_count), 32'h0);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 4'h1, 32'h00000077);
`ifdef RECIRC_COUNT_EN
      chk("sat_count", 100 + k, 32'(bus.recirc_count), (k < CMAX) ? k : CMAX);
`else
      chk("sat_count", 100 + k, 32'(bus.recirc_count), 32'h0);
`endif
      chk("sat_valid", 100 + k, 32'(bus.valid_recirc_out), 32'h1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
